// File: rtl/mem_access_stage.sv
// Registered memory-access stage between EX and WB: drives the memory controller
// with a held request/fin handshake, extends sub-word loads and flags exceptions.
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      ins_type,
  input  logic [2:0]      ins_details,
  input  logic [RA_W-1:0] rd_addr,
  input  logic [XLEN-1:0] rd_val,
  input  logic            wb_en,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_val,
  output logic [1:0]      memctl_op,
  output logic [1:0]      memctl_len,
  output logic [XLEN-1:0] memctl_addr,
  output logic [XLEN-1:0] memctl_data,
  input  logic            memctl_fin,
  input  logic [XLEN-1:0] memctl_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RA_W-1:0] out_rd_addr,
  output logic [XLEN-1:0] out_rd_val,
  output logic            out_wb_en,
  output logic [6:0]      out_ins_type,
  output logic [1:0]      out_exc,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd_addr,
  output logic [XLEN-1:0] fwd_rd_val,
  output logic            load_pending,
  output logic [RA_W-1:0] load_pending_rd
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SAVE = 7'b0100011;
  localparam logic [1:0] MC_NOP  = 2'b00;
  localparam logic [1:0] MC_LOAD = 2'b01;
  localparam logic [1:0] MC_SAVE = 2'b10;
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_MISA = 2'b01;
  localparam logic [1:0] EXC_TOUT = 2'b10;

  // Counter holds the number of fin-less ACCESS cycles already spent, so the
  // abort fires on the TIMEOUT-th cycle itself.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              acc_is_load;
  logic [2:0]        acc_f3;
  logic              acc_wb_en;

  logic              is_load;
  logic              is_save;
  logic              f3_ok;
  logic              is_mem;
  logic              misaligned;
  logic              accept;
  logic [XLEN-1:0]   load_ext;

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    is_load    = (ins_type == OP_LOAD);
    is_save    = (ins_type == OP_SAVE);
    f3_ok      = 1'b0;
    if (is_load) begin
      case (ins_details)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                 f3_ok = 1'b0;
      endcase
    end else if (is_save) begin
      case (ins_details)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
    is_mem     = (is_load || is_save) && f3_ok;
    misaligned = is_mem &&
                 (((ins_details[1:0] == 2'b01) && mem_addr[0]) ||
                  ((ins_details[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)));
  end

  always_comb begin
    load_ext = memctl_out;
    case (acc_f3)
      3'b000:  load_ext = {{(XLEN-8){memctl_out[7]}},   memctl_out[7:0]};
      3'b001:  load_ext = {{(XLEN-16){memctl_out[15]}}, memctl_out[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}},            memctl_out[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}},           memctl_out[15:0]};
      default: load_ext = memctl_out;
    endcase
  end

  // Accepting a new instruction wins over everything, which gives the
  // back-to-back HOLD -> next-instruction path without a bubble.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      acc_is_load  <= 1'b0;
      acc_f3       <= 3'b000;
      acc_wb_en    <= 1'b0;
      memctl_op    <= MC_NOP;
      memctl_len   <= 2'b00;
      memctl_addr  <= '0;
      memctl_data  <= '0;
      out_rd_addr  <= '0;
      out_rd_val   <= '0;
      out_wb_en    <= 1'b0;
      out_ins_type <= 7'b0;
      out_exc      <= EXC_NONE;
    end else if (accept) begin
      out_rd_addr  <= rd_addr;
      out_ins_type <= ins_type;
      wait_cnt     <= '0;
      if (is_mem && !misaligned) begin
        state       <= ACCESS;
        memctl_op   <= is_load ? MC_LOAD : MC_SAVE;
        memctl_len  <= ins_details[1:0];
        memctl_addr <= mem_addr;
        memctl_data <= is_load ? '0 : mem_val;
        acc_is_load <= is_load;
        acc_f3      <= ins_details;
        acc_wb_en   <= wb_en;
        out_rd_val  <= '0;
        out_wb_en   <= 1'b0;
        out_exc     <= EXC_NONE;
      end else if (misaligned) begin
        state       <= HOLD;
        out_rd_val  <= '0;
        out_wb_en   <= 1'b0;
        out_exc     <= EXC_MISA;
      end else begin
        state       <= HOLD;
        out_rd_val  <= rd_val;
        out_wb_en   <= wb_en && !(is_load || is_save);
        out_exc     <= EXC_NONE;
      end
    end else begin
      case (state)
        ACCESS: begin
          if (memctl_fin) begin
            state      <= HOLD;
            memctl_op  <= MC_NOP;
            wait_cnt   <= '0;
            out_exc    <= EXC_NONE;
            out_rd_val <= acc_is_load ? load_ext : '0;
            out_wb_en  <= acc_is_load && acc_wb_en;
          end else if (wait_cnt == CNT_LAST) begin
            state      <= HOLD;
            memctl_op  <= MC_NOP;
            wait_cnt   <= '0;
            out_exc    <= EXC_TOUT;
            out_rd_val <= '0;
            out_wb_en  <= 1'b0;
          end else begin
            wait_cnt   <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    fwd_valid       = out_valid && out_wb_en && (out_rd_addr != '0);
    fwd_rd_addr     = fwd_valid ? out_rd_addr : '0;
    fwd_rd_val      = fwd_valid ? out_rd_val  : '0;
    load_pending    = (state == ACCESS) && acc_is_load;
    load_pending_rd = load_pending ? out_rd_addr : '0;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions push expected WB
// results, a monitor pops them on each WB handshake, a responder plays memctl.
module tb_mem_access_stage;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SAVE = 7'b0100011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  ins_type;
  logic [2:0]  ins_details;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val;
  logic        wb_en;
  logic [31:0] mem_addr, mem_val;
  logic [1:0]  memctl_op, memctl_len;
  logic [31:0] memctl_addr, memctl_data;
  logic        memctl_fin;
  logic [31:0] memctl_out;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_val;
  logic        out_wb_en;
  logic [6:0]  out_ins_type;
  logic [1:0]  out_exc;
  logic        fwd_valid;
  logic [4:0]  fwd_rd_addr;
  logic [31:0] fwd_rd_val;
  logic        load_pending;
  logic [4:0]  load_pending_rd;

  mem_access_stage #(.XLEN(32), .RA_W(5), .TIMEOUT(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ins_type(ins_type), .ins_details(ins_details),
    .rd_addr(rd_addr), .rd_val(rd_val), .wb_en(wb_en),
    .mem_addr(mem_addr), .mem_val(mem_val),
    .memctl_op(memctl_op), .memctl_len(memctl_len),
    .memctl_addr(memctl_addr), .memctl_data(memctl_data),
    .memctl_fin(memctl_fin), .memctl_out(memctl_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_addr(out_rd_addr), .out_rd_val(out_rd_val),
    .out_wb_en(out_wb_en), .out_ins_type(out_ins_type), .out_exc(out_exc),
    .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_rd_val(fwd_rd_val),
    .load_pending(load_pending), .load_pending_rd(load_pending_rd)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        wb;
    logic [1:0]  exc;
    logic [6:0]  ins;
    logic        chk_val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // memctl responder configuration, set by the stimulus before each request
  logic [1:0]  exp_op, exp_len;
  logic [31:0] exp_addr, exp_data, resp_data;
  logic [4:0]  exp_lp_rd;
  int          fin_delay = 0;
  int          acc_cycles = 0;
  int          last_len = 0;
  int          total_requests = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [6:0] ins, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [31:0] rval, input logic wb,
                               input logic [31:0] addr, input logic [31:0] val);
    int n = 0;
    @(posedge clk); #1;
    ins_type = ins; ins_details = f3; rd_addr = rd; rd_val = rval;
    wb_en = wb; mem_addr = addr; mem_val = val; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      n++;
      if (in_ready || n > 50) break;
    end
    checkOutput("accept_wait", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic [31:0] val, input logic wb,
                         input logic [1:0] exc, input logic [6:0] ins, input logic chk);
    exp_t e;
    e.rd = rd; e.val = val; e.wb = wb; e.exc = exc; e.ins = ins; e.chk_val = chk;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic memOp(input logic [6:0] ins, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] val, input int fdel,
                       input logic [31:0] resp, input logic [1:0] eop, input logic [1:0] elen,
                       input logic [31:0] eval, input logic ewb, input logic [1:0] eexc,
                       input logic chk);
    exp_op = eop; exp_len = elen; exp_addr = addr; exp_data = val;
    exp_lp_rd = rd; fin_delay = fdel; resp_data = resp;
    pushExp(rd, eval, ewb, eexc, ins, chk);
    applyStimulus(ins, f3, rd, 32'h0, 1'b1, addr, val);
    drain();
  endtask

  // WB-side monitor: every handshake must match the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_output: rd=%0d val=0x%0h, expected no output", out_rd_addr, out_rd_val);
        end else begin
          e = sb.pop_front();
          checkOutput("out_rd_addr", 64'(out_rd_addr), 64'(e.rd));
          checkOutput("out_wb_en", 64'(out_wb_en), 64'(e.wb));
          checkOutput("out_exc", 64'(out_exc), 64'(e.exc));
          checkOutput("out_ins_type", 64'(out_ins_type), 64'(e.ins));
          if (e.chk_val) checkOutput("out_rd_val", 64'(out_rd_val), 64'(e.val));
          checkOutput("fwd_valid", 64'(fwd_valid), 64'(e.wb && e.rd != 0));
          checkOutput("fwd_rd_val", 64'(fwd_rd_val), (e.wb && e.rd != 0) ? 64'(e.val) : 64'd0);
        end
      end
    end
  end

  // Memory-controller responder: checks the held request every ACCESS cycle
  initial begin
    memctl_fin = 1'b0;
    memctl_out = 32'h0;
    forever begin
      @(negedge clk);
      memctl_fin = 1'b0;
      if (rst_n && memctl_op != 2'b00) begin
        acc_cycles++;
        if (acc_cycles == 1) total_requests++;
        checkOutput("memctl_op", 64'(memctl_op), 64'(exp_op));
        checkOutput("memctl_len", 64'(memctl_len), 64'(exp_len));
        checkOutput("memctl_addr", 64'(memctl_addr), 64'(exp_addr));
        if (exp_op == 2'b10) checkOutput("memctl_data", 64'(memctl_data), 64'(exp_data));
        checkOutput("load_pending", 64'(load_pending), 64'(exp_op == 2'b01));
        checkOutput("load_pending_rd", 64'(load_pending_rd), (exp_op == 2'b01) ? 64'(exp_lp_rd) : 64'd0);
        if (fin_delay != 0 && acc_cycles == fin_delay) begin
          memctl_fin = 1'b1;
          memctl_out = resp_data;
        end
      end else begin
        if (acc_cycles != 0) last_len = acc_cycles;
        acc_cycles = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int req_before;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ins_type = 7'b0; ins_details = 3'b0; rd_addr = 5'd0; rd_val = 32'h0;
    wb_en = 1'b0; mem_addr = 32'h0; mem_val = 32'h0;
    exp_op = 2'b00; exp_len = 2'b00; exp_addr = 32'h0; exp_data = 32'h0;
    exp_lp_rd = 5'd0; resp_data = 32'h0;

    #3;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_memctl_op", 64'(memctl_op), 64'd0);
    checkOutput("rst_memctl_addr", 64'(memctl_addr), 64'd0);
    checkOutput("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    checkOutput("rst_load_pending", 64'(load_pending), 64'd0);
    checkOutput("rst_out_exc", 64'(out_exc), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Non-memory op: result one cycle after acceptance, forwarded
    pushExp(5'd5, 32'h1234, 1'b1, 2'b00, OP_ALU, 1'b1);
    applyStimulus(OP_ALU, 3'b000, 5'd5, 32'h1234, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("alu_out_valid_latency", 64'(out_valid), 64'd1);
    checkOutput("alu_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Non-memory without write enable, and write to x0: never forwarded
    pushExp(5'd3, 32'hAAAA5555, 1'b0, 2'b00, OP_ALU, 1'b1);
    applyStimulus(OP_ALU, 3'b000, 5'd3, 32'hAAAA5555, 1'b0, 32'h0, 32'h0);
    drain();
    pushExp(5'd0, 32'h77, 1'b1, 2'b00, OP_ALU, 1'b1);
    applyStimulus(OP_ALU, 3'b000, 5'd0, 32'h77, 1'b1, 32'h0, 32'h0);
    drain();

    // Sub-word loads with extension
    memOp(OP_LOAD, 3'b000, 5'd6, 32'h100, 32'h0, 3, 32'h80, 2'b01, 2'b00, 32'hFFFFFF80, 1'b1, 2'b00, 1'b1);
    checkOutput("lb_access_cycles", 64'(last_len), 64'd3);
    memOp(OP_LOAD, 3'b100, 5'd6, 32'h100, 32'h0, 3, 32'h80, 2'b01, 2'b00, 32'h00000080, 1'b1, 2'b00, 1'b1);
    memOp(OP_LOAD, 3'b001, 5'd10, 32'h100, 32'h0, 1, 32'h8001, 2'b01, 2'b01, 32'hFFFF8001, 1'b1, 2'b00, 1'b1);
    checkOutput("lh_access_cycles", 64'(last_len), 64'd1);
    memOp(OP_LOAD, 3'b101, 5'd11, 32'h102, 32'h0, 2, 32'h12348001, 2'b01, 2'b01, 32'h00008001, 1'b1, 2'b00, 1'b1);
    memOp(OP_LOAD, 3'b010, 5'd12, 32'h104, 32'h0, 2, 32'hDEADBEEF, 2'b01, 2'b10, 32'hDEADBEEF, 1'b1, 2'b00, 1'b1);

    // Misaligned word store: no request, exception 01
    req_before = total_requests;
    memOp(OP_SAVE, 3'b010, 5'd0, 32'h202, 32'h11223344, 0, 32'h0, 2'b10, 2'b10, 32'h0, 1'b0, 2'b01, 1'b0);
    checkOutput("sw_misaligned_no_request", 64'(total_requests), 64'(req_before));
    memOp(OP_LOAD, 3'b001, 5'd13, 32'h101, 32'h0, 0, 32'h0, 2'b01, 2'b01, 32'h0, 1'b0, 2'b01, 1'b0);

    // Aligned half store at the same address issues a normal SAVE
    req_before = total_requests;
    memOp(OP_SAVE, 3'b001, 5'd4, 32'h202, 32'h0000BEEF, 2, 32'h0, 2'b10, 2'b01, 32'h0, 1'b0, 2'b00, 1'b0);
    checkOutput("sh_request_issued", 64'(total_requests), 64'(req_before + 1));

    // Undefined load funct3: no request, write suppressed
    req_before = total_requests;
    pushExp(5'd8, 32'h0, 1'b0, 2'b00, OP_LOAD, 1'b0);
    applyStimulus(OP_LOAD, 3'b011, 5'd8, 32'h55, 1'b1, 32'h300, 32'h0);
    drain();
    checkOutput("undef_f3_no_request", 64'(total_requests), 64'(req_before));

    // Timeout with no fin, then fin exactly on the abort cycle
    memOp(OP_LOAD, 3'b010, 5'd7, 32'h300, 32'h0, 0, 32'h0, 2'b01, 2'b10, 32'h0, 1'b0, 2'b10, 1'b0);
    checkOutput("timeout_access_cycles", 64'(last_len), 64'd4);
    memOp(OP_LOAD, 3'b010, 5'd7, 32'h300, 32'h0, 4, 32'hCAFEF00D, 2'b01, 2'b10, 32'hCAFEF00D, 1'b1, 2'b00, 1'b1);
    checkOutput("fin_on_abort_cycles", 64'(last_len), 64'd4);

    // WB backpressure for 5 cycles with a queued instruction behind it
    pushExp(5'd14, 32'h0BADF00D, 1'b1, 2'b00, OP_ALU, 1'b1);
    pushExp(5'd15, 32'h600DCAFE, 1'b1, 2'b00, OP_ALU, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    ins_type = OP_ALU; ins_details = 3'b000; rd_addr = 5'd14; rd_val = 32'h0BADF00D;
    wb_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rd_addr = 5'd15; rd_val = 32'h600DCAFE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_rd_val", 64'(out_rd_val), 64'h0BADF00D);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_out_rd_addr", 64'(out_rd_addr), 64'd15);
    drain();

    // Asynchronous reset in the middle of an access
    exp_op = 2'b01; exp_len = 2'b10; exp_addr = 32'h400; exp_lp_rd = 5'd9; fin_delay = 0;
    applyStimulus(OP_LOAD, 3'b010, 5'd9, 32'h0, 1'b1, 32'h400, 32'h0);
    @(negedge clk);
    checkOutput("pre_reset_memctl_op", 64'(memctl_op), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_memctl_op", 64'(memctl_op), 64'd0);
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_load_pending", 64'(load_pending), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("post_rst_memctl_op", 64'(memctl_op), 64'd0);
    pushExp(5'd21, 32'h13579BDF, 1'b1, 2'b00, OP_ALU, 1'b1);
    applyStimulus(OP_ALU, 3'b000, 5'd21, 32'h13579BDF, 1'b1, 32'h0, 32'h0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Parametrised, registered successor to the combinational memory stage. Sits between EX and WB and drives the memory controller with a held request/fin handshake.
- Adds valid/ready pipeline handshakes, correct sub-word sign/zero extension, misalignment detection and a controller timeout.
- Exposes forwarding and load-pending hazard outputs.

Parameters:
XLEN, 32, data/address width
RA_W, 5, register-address width
TIMEOUT, 255, max cycles waiting for memctl_fin before error (>=1)

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
in_valid  in  1  EX result valid
in_ready  out  1  stage can accept
ins_type  in  7  opcode; LOAD=7'b0000011, SAVE=7'b0100011, others = non-memory
ins_details  in  3  funct3: LB000 LH001 LW010 LBU100 LHU101; SB000 SH001 SW010
rd_addr  in  RA_W  destination register
rd_val  in  XLEN  EX result (non-memory ops)
wb_en  in  1  instruction writes rd
mem_addr  in  XLEN  effective address
mem_val  in  XLEN  store data, right-aligned
memctl_op  out  2  00 NOP, 01 LOAD, 10 SAVE
memctl_len  out  2  00 byte, 01 half, 10 word
memctl_addr  out  XLEN  request address
memctl_data  out  XLEN  store data
memctl_fin  in  1  request complete (one-cycle pulse)
memctl_out  in  XLEN  load data, right-aligned
out_valid  out  1  WB result valid
out_ready  in  1  WB accepts
out_rd_addr  out  RA_W  result register
out_rd_val  out  XLEN  result value
out_wb_en  out  1  write enable (0 on exception/store)
out_ins_type  out  7  passed-through opcode
out_exc  out  2  00 none, 01 misaligned, 10 timeout
fwd_valid  out  1  forward valid
fwd_rd_addr  out  RA_W  forward register
fwd_rd_val  out  XLEN  forward value
load_pending  out  1  load in flight (hazard unit stalls dependants)
load_pending_rd  out  RA_W  rd of in-flight load

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; all outputs 0 except in_ready=1; memctl_op=NOP immediately, including mid-access; timeout counter 0.
- States: IDLE, ACCESS, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
- Accept occurs on in_valid && in_ready.
- Non-memory op: registered into the output regs; next state HOLD. Latency 1 cycle. out_rd_val=rd_val, out_wb_en=wb_en, out_exc=00.
- Misaligned memory op goes directly to HOLD with out_exc=01, out_wb_en=0, no memctl request. Misaligned means: half ops with addr[0]!=0; word ops with addr[1:0]!=0.
- Undefined funct3 for LOAD/SAVE is treated as a non-memory op with out_wb_en=0.
- Aligned memory op: next state ACCESS. memctl_op/len/addr/data are registered and held stable until the cycle memctl_fin is sampled high.
- On memctl_fin in ACCESS:
  - memctl_op->NOP on the same edge.
  - Load result captured: LB sign-extends bit7; LH sign-extends bit15; LBU/LHU zero-extend; LW passes through.
  - Next state HOLD.
  - Store result: out_wb_en=0.
- Minimum load/store latency: accept edge + fin edge.
- Timeout: counter increments each ACCESS cycle without fin. At count==TIMEOUT, abort: memctl_op->NOP, out_exc=10, out_wb_en=0, next state HOLD. A fin arriving in the same cycle as the abort takes priority (normal completion).
- HOLD: out_valid=1, outputs stable while out_ready=0.
  - out_ready=1 with in_valid=1: new instruction accepted same edge (back-to-back, no bubble).
  - out_ready=1 without in_valid: go to IDLE.
- load_pending=1 in ACCESS when the op is a load; load_pending_rd=its rd, else 0.
- fwd_valid = out_valid && out_wb_en && out_rd_addr!=0. fwd_rd_addr/val mirror the output regs, else 0.
- memctl_fin outside ACCESS is ignored.

Test Plan:
- Non-memory: rd_addr=5, rd_val=0x1234, wb_en=1, out_ready=1 -> out_valid next cycle, out_rd_val=0x1234, fwd_valid=1, in_ready stays 1.
- LB addr 0x100: memctl_op=01, len=00 held until fin after 3 cycles; memctl_out=0x80 -> out_rd_val=0xFFFFFF80. LBU same data -> 0x00000080. LH with 0x8001 -> 0xFFFF8001.
- SW addr 0x202 -> no memctl request, out_exc=01, out_wb_en=0; SH addr 0x202 -> normal SAVE request, len=01, data=mem_val.
- TIMEOUT=4, fin never asserted -> memctl_op NOP after 4 ACCESS cycles, out_exc=10. Repeat with fin on cycle 4 -> normal completion.
- out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; then out_ready=1 with a queued in_valid -> accepted same edge.
- Assert rst_n_in low mid-ACCESS -> memctl_op=00 and out_valid=0 without a clock edge; after release, state IDLE.
